data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

- Two-requester arbiter and sequencer for the byte-addressed, 64-bit-word data memory.
- Accepts doubleword load/store requests from two masters (requester 0: pipeline MEM stage; requester 1: debug/DMA port) and grants one at a time.
- Drives the memory's address, write-data and read/write strobes for exactly one access cycle, then returns the read word and an acknowledge.
- Sits between the requesters and the data memory; the memory keeps its combinational read and posedge write.

## Interface
Parameters:
- MEM_BYTES, 1024: memory size in bytes; legal access iff addr + 7 < MEM_BYTES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 request; level, held until r0_ack.
- r0_we  in  1  1 = store, 0 = load; stable while r0_req.
- r0_addr  in  64  byte address; stable while r0_req.
- r0_wdata  in  64  store data; stable while r0_req.
- r0_ack  out  1  one-cycle completion pulse.
- r0_err  out  1  pulses with r0_ack when the address is out of range.
- r0_rdata  out  64  load result; valid while r0_ack.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as the r0_* ports, for requester 1.
- mem_addr  out  64  memory address.
- mem_wdata  out  64  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  64  memory combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If no req: stay in IDLE.
  - Else pick a winner and latch its we/addr/wdata into mem_* registers.
  - Go to ACCESS if the address is in range, else go to RESP with an error flagged.
- **ACCESS:**
  - mem_read = !we, mem_write = we.
  - The memory commits a store at the edge ending ACCESS.
  - For a load, mem_rdata is captured into the winner's rdata register at that edge.
  - Go to RESP.
- **RESP:**
  - Winner's ack = 1; err = 1 only if range error.
  - For an error: no memory strobe was issued, and rdata = 0.
  - For a store: rdata holds its previous value.
  - Go to IDLE.
- Requests are sampled only in IDLE. A req still high at the IDLE after RESP is a new transaction.
- Range check: addr + 7 evaluated in 65-bit unsigned arithmetic; legal iff < MEM_BYTES. No alignment requirement.
- Arbitration: see Configuration.
- The loser keeps its req high and is served on the next IDLE decision.
- mem_addr and mem_wdata retain their last values outside ACCESS.
- mem_read and mem_write are 0 in every state except ACCESS.

## Timing
- Reset values: state IDLE; mem_addr, mem_wdata, mem_write, mem_read = 0; r*_ack, r*_err = 0; r*_rdata = 0; last-grant = 1 (requester 0 wins first tie).
- Reset is asynchronous. Reset asserted during ACCESS drops mem_write immediately, so no store commits at the following edge. The transaction is discarded with no ack.
- Latency, legal access: req seen at edge E0 (IDLE); ACCESS in cycle E0..E1; ack high in cycle E1..E2.
  - Ack appears 2 cycles after the sampling edge.
  - Back-to-back throughput: one access per 3 cycles.
- Latency, out-of-range access: ack/err 1 cycle after the sampling edge; ACCESS is skipped.
- All outputs are registered; there are no combinational paths from requester inputs to mem_* or ack.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the requester not granted last wins.
  - last-grant updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, requester 0 always wins.
  - The last-grant register is not implemented.

## Test plan
- **Single store then load (r0):** store addr=16, wdata=0x1122334455667788.
  - Expect mem_write high for exactly 1 cycle, then r0_ack.
  - A following load at 16 returns r0_rdata=0x1122334455667788 with r0_ack 2 cycles after sampling.
- **Simultaneous requests, RR_EN defined:** r0 and r1 load held continuously.
  - Expect grants alternating 0,1,0,1, starting with 0 after reset, with acks every 3 cycles.
- **Simultaneous requests, RR_EN undefined:** same stimulus.
  - Expect r0 serviced every transaction and r1 starved until r0_req drops, then r1_ack.
- **Out-of-range access:** r1 load at addr=1020 with MEM_BYTES=1024.
  - Expect r1_ack and r1_err together, 1 cycle after sampling; mem_read never asserted; r1_rdata=0.
- **Boundary legal access:** addr=1016 load.
  - Expect no err and bytes 1016..1023 returned little-endian.
- **Reset mid-ACCESS:** assert reset during a store's ACCESS cycle.
  - Expect mem_write=0 immediately, memory unchanged at that address, no ack, and all outputs at reset values.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester arbiter and sequencer for a byte-addressed,
// 64-bit-word data memory with combinational read and posedge write.
// Each transaction runs IDLE -> ACCESS -> RESP. An out-of-range access skips
// ACCESS and goes straight to RESP with an error.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration.
// When the macro is undefined, requester 0 has fixed priority.
module data_memory_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [63:0] r0_addr,
    input  logic [63:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [63:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [63:0] r1_addr,
    input  logic [63:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [63:0] r1_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        winner;     // requester owning the current transaction
    logic        cur_we;     // direction of the current transaction
    logic        any_req;
    logic        pick;       // 0 = requester 0, 1 = requester 1
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_in_range;

`ifdef DMEM_ARB_RR_EN
    logic        last_grant;

    // Round-robin choice: on a tie, the requester not granted last wins.
    always_comb begin
        any_req = r0_req | r1_req;
        if (r0_req && r1_req) begin
            pick = ~last_grant;
        end else begin
            pick = ~r0_req;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= pick;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting.
    always_comb begin
        any_req = r0_req | r1_req;
        pick    = ~r0_req;
    end
`endif

    // Mux the chosen requester and range-check it in 65-bit unsigned arithmetic.
    always_comb begin
        sel_we       = pick ? r1_we    : r0_we;
        sel_addr     = pick ? r1_addr  : r0_addr;
        sel_wdata    = pick ? r1_wdata : r0_wdata;
        sel_in_range = (({1'b0, sel_addr} + 65'd7) < 65'(MEM_BYTES));
    end

    // Transaction sequencer. All outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            winner    <= 1'b0;
            cur_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            r0_ack    <= 1'b0;
            r0_err    <= 1'b0;
            r0_rdata  <= 64'd0;
            r1_ack    <= 1'b0;
            r1_err    <= 1'b0;
            r1_rdata  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner    <= pick;
                        cur_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        if (sel_in_range) begin
                            // Strobes are set now so they are high for the whole ACCESS cycle.
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                            state     <= ACCESS;
                        end else begin
                            // No memory strobe; respond right away with an error and zero data.
                            state <= RESP;
                            if (pick) begin
                                r1_ack   <= 1'b1;
                                r1_err   <= 1'b1;
                                r1_rdata <= 64'd0;
                            end else begin
                                r0_ack   <= 1'b1;
                                r0_err   <= 1'b1;
                                r0_rdata <= 64'd0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // The memory commits a store, or presents load data, at this edge.
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state     <= RESP;
                    if (winner) begin
                        r1_ack <= 1'b1;
                        if (!cur_we) begin
                            r1_rdata <= mem_rdata;
                        end
                    end else begin
                        r0_ack <= 1'b1;
                        if (!cur_we) begin
                            r0_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    r0_ack <= 1'b0;
                    r0_err <= 1'b0;
                    r1_ack <= 1'b0;
                    r1_err <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed bench for data_memory_arbiter with a
// byte-array memory model (combinational little-endian read, posedge write).
// Compile with DMEM_ARB_RR_EN defined to exercise round-robin arbitration.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we;
    logic [63:0] r0_addr, r0_wdata;
    logic        r0_ack, r0_err;
    logic [63:0] r0_rdata;
    logic        r1_req, r1_we;
    logic [63:0] r1_addr, r1_wdata;
    logic        r1_ack, r1_err;
    logic [63:0] r1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [7:0]  mem [0:1023];
    int          checks = 0;
    int          errors = 0;

    data_memory_arbiter #(.MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational little-endian read.
    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (mem_addr + 64'(i) < 64'd1024) begin
                mem_rdata[8*i +: 8] = mem[10'(mem_addr + 64'(i))];
            end
        end
    end

    // Memory model: posedge write.
    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_addr + 64'(i) < 64'd1024) begin
                    mem[10'(mem_addr + 64'(i))] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    function automatic logic [63:0] read_word(input int a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem[a + i];
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[1016 + i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 8; i++) mem[24 + i] = 8'h5A;

        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        #3;
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_r0_ack", 64'(r0_ack), 64'd0);
        check("rst_r1_ack", 64'(r1_ack), 64'd0);
        check("rst_r0_rdata", r0_rdata, 64'd0);
        step(); step();
        #2 reset = 1'b0;
        step();

        // Store r0 @16
        r0_req = 1; r0_we = 1; r0_addr = 64'd16; r0_wdata = 64'h1122334455667788;
        step();
        check("st_access_write", 64'(mem_write), 64'd1);
        check("st_access_read", 64'(mem_read), 64'd0);
        check("st_access_addr", mem_addr, 64'd16);
        check("st_access_wdata", mem_wdata, 64'h1122334455667788);
        check("st_access_noack", 64'(r0_ack), 64'd0);
        step();
        check("st_resp_write", 64'(mem_write), 64'd0);
        check("st_resp_ack", 64'(r0_ack), 64'd1);
        check("st_resp_err", 64'(r0_err), 64'd0);
        check("st_resp_r1ack", 64'(r1_ack), 64'd0);
        check("st_mem_word", read_word(16), 64'h1122334455667788);
        r0_req = 0;
        step();
        check("st_idle_ack", 64'(r0_ack), 64'd0);

        // Load r0 @16
        r0_req = 1; r0_we = 0; r0_addr = 64'd16; r0_wdata = 64'd0;
        step();
        check("ld_access_read", 64'(mem_read), 64'd1);
        check("ld_access_write", 64'(mem_write), 64'd0);
        check("ld_access_noack", 64'(r0_ack), 64'd0);
        step();
        check("ld_resp_ack", 64'(r0_ack), 64'd1);
        check("ld_resp_rdata", r0_rdata, 64'h1122334455667788);
        check("ld_resp_read", 64'(mem_read), 64'd0);
        r0_req = 0;
        step();

        // Boundary legal load r1 @1016
        r1_req = 1; r1_we = 0; r1_addr = 64'd1016;
        step();
        check("bnd_access_read", 64'(mem_read), 64'd1);
        step();
        check("bnd_resp_ack", 64'(r1_ack), 64'd1);
        check("bnd_resp_err", 64'(r1_err), 64'd0);
        check("bnd_resp_rdata", r1_rdata, 64'hA7A6A5A4A3A2A1A0);
        r1_req = 0;
        step();

        // Out-of-range load r1 @1020
        r1_req = 1; r1_we = 0; r1_addr = 64'd1020;
        step();
        check("oor_ack", 64'(r1_ack), 64'd1);
        check("oor_err", 64'(r1_err), 64'd1);
        check("oor_rdata", r1_rdata, 64'd0);
        check("oor_read", 64'(mem_read), 64'd0);
        check("oor_r0_ack", 64'(r0_ack), 64'd0);
        r1_req = 0;
        step();
        check("oor_after_ack", 64'(r1_ack), 64'd0);
        check("oor_after_read", 64'(mem_read), 64'd0);

        // Simultaneous loads: r0 @16, r1 @1016
        r0_req = 1; r0_we = 0; r0_addr = 64'd16;
        r1_req = 1; r1_we = 0; r1_addr = 64'd1016;
        for (int t = 0; t < 4; t++) begin
`ifdef DMEM_ARB_RR_EN
            exp1 = (t % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            step();
            check("sim_access_noack", 64'({r0_ack, r1_ack}), 64'd0);
            step();
            check("sim_r0_ack", 64'(r0_ack), 64'(!exp1));
            check("sim_r1_ack", 64'(r1_ack), 64'(exp1));
            if (exp1) check("sim_r1_rdata", r1_rdata, 64'hA7A6A5A4A3A2A1A0);
            else      check("sim_r0_rdata", r0_rdata, 64'h1122334455667788);
            if (t == 3) r0_req = 0;
            step();
            check("sim_idle_noack", 64'({r0_ack, r1_ack}), 64'd0);
        end
        step();
        step();
        check("sim_tail_r1_ack", 64'(r1_ack), 64'd1);
        check("sim_tail_r0_ack", 64'(r0_ack), 64'd0);
        r1_req = 0;
        step();

        // Reset during a store's ACCESS cycle
        r0_req = 1; r0_we = 1; r0_addr = 64'd24; r0_wdata = 64'hDEADBEEFCAFEF00D;
        step();
        check("rma_access_write", 64'(mem_write), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rma_write_drop", 64'(mem_write), 64'd0);
        check("rma_mem_addr", mem_addr, 64'd0);
        check("rma_mem_wdata", mem_wdata, 64'd0);
        check("rma_r0_rdata", r0_rdata, 64'd0);
        check("rma_r1_rdata", r1_rdata, 64'd0);
        check("rma_r0_ack", 64'(r0_ack), 64'd0);
        step();
        check("rma_mem_unchanged", read_word(24), 64'h5A5A5A5A5A5A5A5A);
        r0_req = 0;
        #2 reset = 1'b0;
        step();
        check("rma_no_ack1", 64'(r0_ack), 64'd0);
        step();
        check("rma_no_ack2", 64'(r0_ack), 64'd0);
        check("rma_idle_write", 64'(mem_write), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
